// File: rtl/sub_bytes_iter_pkg.sv
// Shared AES definitions: state geometry, FSM encoding and GF(2^8) helpers
// used by the iterative SubBytes block and its S-box lanes.
package sub_bytes_iter_pkg;

  localparam int unsigned STATE_W   = 128;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned NUM_BYTES = 16;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned OFF_W     = $clog2(STATE_W);

  // Additive constant of the S-box affine transform
  localparam logic [7:0] AFFINE_C = 8'h63;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_state_e;

  function automatic bit is_legal_bpc(input int unsigned n);
    return (n == 1) || (n == 2) || (n == 4) || (n == 8) || (n == 16);
  endfunction

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

endpackage

// File: rtl/sub_bytes_iter_s_box.sv
// Combinational AES forward S-box: GF(2^8) inverse followed by the affine map.
// Ports use MSB-first [0:7] ordering to match the state byte layout.
module s_box
  import sub_bytes_iter_pkg::*;
(
  input  logic [0:BYTE_W-1] data,
  output logic [0:BYTE_W-1] result
);

  logic [7:0] inv;
  logic [7:0] aff;

  assign inv = gf_inv(data);

  // b'[i] = b[i] ^ b[i+4] ^ b[i+5] ^ b[i+6] ^ b[i+7] ^ c[i], indices mod 8
  always_comb begin
    aff = '0;
    for (int i = 0; i < 8; i++) begin
      aff[i] = inv[i] ^ inv[3'(i + 4)] ^ inv[3'(i + 5)] ^ inv[3'(i + 6)]
             ^ inv[3'(i + 7)] ^ AFFINE_C[i];
    end
  end

  assign result = aff;

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: captures a 128-bit state and substitutes
// BYTES_PER_CYCLE bytes per cycle in place, then holds the result until taken.
module sub_bytes_iter
  import sub_bytes_iter_pkg::*;
#(
  parameter int unsigned BYTES_PER_CYCLE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [0:STATE_W-1] state_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [0:STATE_W-1] state_out,
  output logic               busy
);

  if (!is_legal_bpc(BYTES_PER_CYCLE)) begin : g_bad_bpc
    $error("sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - BYTES_PER_CYCLE);
  // Truncates to 0 when all 16 bytes go in one cycle; idx is never advanced then
  localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(BYTES_PER_CYCLE);

  fsm_state_e         state;
  logic [IDX_W-1:0]   idx;
  logic [0:STATE_W-1] work;

  logic [OFF_W-1:0]  lane_off [BYTES_PER_CYCLE];
  logic [0:BYTE_W-1] lane_in  [BYTES_PER_CYCLE];
  logic [0:BYTE_W-1] lane_out [BYTES_PER_CYCLE];

  // Each lane looks at byte idx+j of the working register
  for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lane
    assign lane_off[j] = OFF_W'((int'(idx) + j) * BYTE_W);
    assign lane_in[j]  = work[lane_off[j] +: BYTE_W];

    s_box u_s_box (
      .data   (lane_in[j]),
      .result (lane_out[j])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      work      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= state_in;
            idx      <= '0;
            state    <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          for (int unsigned j = 0; j < BYTES_PER_CYCLE; j++) begin
            work[lane_off[j] +: BYTE_W] <= lane_out[j];
          end
          // Final group: stop without letting idx wrap into a second pass
          if (idx == LAST_IDX) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + IDX_STEP;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign state_out = work;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Self-checking bench for sub_bytes_iter at BYTES_PER_CYCLE 4, 1 and 16,
// checked against a log/antilog-table S-box model built inside the bench.
module tb_sub_bytes_iter;

  localparam int unsigned NU = 3;

  logic         clk;
  logic         rst_n;
  logic         iv   [NU];
  logic         ir   [NU];
  logic [127:0] si   [NU];
  logic         ov   [NU];
  logic         ordy [NU];
  logic [127:0] so   [NU];
  logic         bz   [NU];

  int n_cmp;
  int n_err;

  logic [7:0] sbox_tbl [256];

  sub_bytes_iter #(.BYTES_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .state_in(si[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .state_out(so[0]), .busy(bz[0]));

  sub_bytes_iter #(.BYTES_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .state_in(si[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .state_out(so[1]), .busy(bz[1]));

  sub_bytes_iter #(.BYTES_PER_CYCLE(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .state_in(si[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .state_out(so[2]), .busy(bz[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bpc_of(input int u);
    case (u)
      0:       return 4;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from powers of generator 3: inverse of 3^i is 3^(255-i)
  task automatic build_sbox();
    logic [7:0] ex [255];
    int         lg [256];
    logic [7:0] v;
    logic [7:0] inv;
    ex[0] = 8'h01;
    for (int i = 1; i < 255; i++)
      ex[i] = ex[i-1] ^ {ex[i-1][6:0], 1'b0} ^ (ex[i-1][7] ? 8'h1b : 8'h00);
    for (int i = 0; i < 256; i++) lg[i] = 0;
    for (int i = 0; i < 255; i++) lg[ex[i]] = i;
    for (int x = 0; x < 256; x++) begin
      v   = 8'(x);
      inv = (v == 8'h00) ? 8'h00 : ex[(255 - lg[v]) % 255];
      sbox_tbl[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] st);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = sbox_tbl[st[127-8*k -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer st to unit u at the current negedge; lat counts negedges until out_valid
  task automatic run_txn(input int u, input logic [127:0] st,
                         output int lat, output logic [127:0] res);
    chk("accept_ready", 128'(ir[u]), 128'(1));
    iv[u] = 1'b1;
    si[u] = st;
    lat   = 0;
    do begin
      @(negedge clk);
      iv[u] = 1'b0;
      lat++;
    end while (!ov[u] && lat < 40);
    res = so[u];
    if (ordy[u]) @(negedge clk);
  endtask

  logic [7:0]   pat_in  [4];
  logic [7:0]   pat_out [4];
  logic [127:0] st_a;
  logic [127:0] st_b;
  logic [127:0] res;
  logic [127:0] fips_in;
  logic [127:0] fips_out;
  logic [127:0] q [$];
  int           lat;
  int           got;
  int           cyc;
  int           last_t;
  bit           flag;

  initial begin
    n_cmp = 0;
    n_err = 0;
    build_sbox();
    pat_in   = '{8'h00, 8'h01, 8'h53, 8'hff};
    pat_out  = '{8'h63, 8'h7c, 8'hed, 8'h16};
    fips_in  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    fips_out = 128'hd42711aee0bf98f1b8b45de51e415230;
    for (int u = 0; u < NU; u++) begin
      iv[u] = 1'b0; si[u] = '0; ordy[u] = 1'b1;
    end

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      chk("rst_in_ready", 128'(ir[u]), 128'(1));
      chk("rst_out_valid", 128'(ov[u]), 128'(0));
      chk("rst_busy", 128'(bz[u]), 128'(0));
      chk("rst_state_out", so[u], 128'(0));
    end
    rst_n = 1'b1;

    // Uniform-byte patterns; the first is offered on the edge right after release
    for (int p = 0; p < 4; p++) begin
      run_txn(0, {16{pat_in[p]}}, lat, res);
      chk("pattern_result", res, {16{pat_out[p]}});
      chk("pattern_latency", 128'(lat), 128'(5));
    end

    run_txn(0, fips_in, lat, res);
    chk("fips_result", res, fips_out);
    chk("fips_latency", 128'(lat), 128'(5));

    for (int i = 0; i < 8; i++) begin
      st_a = rand128();
      run_txn(0, st_a, lat, res);
      chk("random_result", res, ref_sub(st_a));
      chk("random_latency", 128'(lat), 128'(5));
    end

    // Backpressure: hold DONE for 10 cycles
    st_a = rand128();
    ordy[0] = 1'b0;
    run_txn(0, st_a, lat, res);
    chk("bp_latency", 128'(lat), 128'(5));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 128'(ov[0]), 128'(1));
      chk("bp_state_out", so[0], ref_sub(st_a));
      chk("bp_in_ready", 128'(ir[0]), 128'(0));
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 128'(ov[0]), 128'(0));
    chk("bp_release_ready", 128'(ir[0]), 128'(1));

    // Second offer while busy must be ignored
    st_a = rand128();
    st_b = ~st_a;
    chk("rej_ready", 128'(ir[0]), 128'(1));
    iv[0] = 1'b1; si[0] = st_a;
    @(negedge clk);
    lat = 1;
    chk("rej_busy", 128'(bz[0]), 128'(1));
    chk("rej_in_ready", 128'(ir[0]), 128'(0));
    si[0] = st_b;
    @(negedge clk);
    lat = 2;
    chk("rej_in_ready2", 128'(ir[0]), 128'(0));
    @(negedge clk);
    lat = 3;
    iv[0] = 1'b0;
    while (!ov[0] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("rej_latency", 128'(lat), 128'(5));
    chk("rej_result", so[0], ref_sub(st_a));
    @(negedge clk);

    // Reset in the second BUSY cycle abandons the transform
    chk("mid_ready", 128'(ir[0]), 128'(1));
    iv[0] = 1'b1; si[0] = rand128();
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(ov[0]), 128'(0));
    chk("mid_rst_ready", 128'(ir[0]), 128'(1));
    chk("mid_rst_busy", 128'(bz[0]), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ov[0] !== 1'b0) flag = 1'b1;
    end
    chk("mid_no_valid_after", 128'(flag), 128'(0));
    st_a = rand128();
    run_txn(0, st_a, lat, res);
    chk("mid_new_result", res, ref_sub(st_a));
    chk("mid_new_latency", 128'(lat), 128'(5));

    // Parameter sweep with the reference vector and random states
    for (int u = 1; u < NU; u++) begin
      run_txn(u, fips_in, lat, res);
      chk("sweep_fips_result", res, fips_out);
      chk("sweep_fips_latency", 128'(lat), 128'(1 + 16 / bpc_of(u)));
      st_a = rand128();
      run_txn(u, st_a, lat, res);
      chk("sweep_random_result", res, ref_sub(st_a));
    end

    // Back-to-back streams: one result every 16/BPC + 2 cycles
    for (int u = 0; u < NU; u++) begin
      q.delete();
      got = 0; cyc = 0; last_t = -1;
      iv[u] = 1'b1;
      while (got < 3 && cyc < 200) begin
        if (ir[u]) begin
          st_a = rand128();
          si[u] = st_a;
          q.push_back(st_a);
        end
        @(negedge clk);
        cyc++;
        if (ov[u]) begin
          if (q.size() == 0) chk("stream_unexpected", 128'(1), 128'(0));
          else chk("stream_result", so[u], ref_sub(q.pop_front()));
          if (last_t >= 0) chk("stream_gap", 128'(cyc - last_t), 128'(16 / bpc_of(u) + 2));
          last_t = cyc;
          got++;
        end
      end
      iv[u] = 1'b0;
      chk("stream_count", 128'(got), 128'(3));
      for (int k = 0; k < 40 && !ir[u]; k++) @(negedge clk);
      chk("stream_drain_ready", 128'(ir[u]), 128'(1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
